// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// Also intended for the transmitter side.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DVSR clocks, with a synchronous
// restart so the receiver can phase-align ticks to a start edge.
module uart_baud_tick #(
  parameter int DVSR = 326
) (
  input  logic ckht,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DVSR > 2) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver, 16x oversampled, LSB first. Emits a one-cycle write
// strobe with the byte, plus framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16,
  parameter int DVSR      = 326
) (
  input  logic                 ckht,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 fifo_full,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);
  localparam logic [3:0]    S_MID     = 4'(MID_SAMPLE);
  localparam logic [3:0]    S_BIT_END = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]    S_STOP    = 4'(SB_TICK - 1);

  logic rx_meta, rx_s, rx_prev, rx_fall;
  logic tick, restart;

  rx_state_t            state_q, state_d;
  logic [3:0]           s_cnt_q, s_cnt_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_d;
  logic                 done_d, ferr_d, ovr_d;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  uart_baud_tick #(.DVSR(DVSR)) u_baud (
    .ckht    (ckht),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_cnt_q      <= '0;
      n_q          <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      n_q          <= n_d;
      shift_q      <= shift_d;
      rx_data      <= data_d;
      rx_done_tick <= done_d;
      frame_err    <= ferr_d;
      overrun_err  <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = rx_data;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          s_cnt_d = '0;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == S_BIT_END) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == S_STOP) begin
            // Leave at mid stop bit so a back-to-back start edge is still seen.
            state_d = IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
              ovr_d  = fifo_full;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path for the DE10-Lite design; the receive-side counterpart of the transmit FIFO path.
- Synchronises the serial `rx` line and oversamples it 16x from an internal baud-tick divider.
- Recovers 8N1 frames, LSB first, and presents each byte as a one-cycle write strobe plus data that connects directly to a FIFO write port (`wr`/`wr_data`).
- Flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, data bits per frame.
- SB_TICK, 16, oversample ticks spent in the stop bit (16 = 1 stop bit).
- DVSR, 326, clock cycles per oversample tick (50 MHz / (16 × 9600)); legal range is 2 or more.

Ports:
- ckht  in  1  FPGA system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input line; idles high; asynchronous to ckht.
- fifo_full  in  1  full flag of the downstream receive FIFO.
- rx_done_tick  out  1  one-cycle strobe: valid byte on rx_data; drives the FIFO `wr` input.
- rx_data  out  DATA_BITS  last received byte; held until the next valid frame.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded.
- overrun_err  out  1  one-cycle pulse: rx_done_tick asserted while fifo_full = 1.

Behaviour:
- Reset (async, active-high): state IDLE; both synchroniser flops = 1; previous-sample flop = 1; divider, s_cnt and n = 0; shift register = 0; rx_data = 0; rx_done_tick, frame_err and overrun_err = 0.
- Synchroniser: 2-flop chain on rx produces rx_s. Edge detector: rx_fall = prev & ~rx_s, with prev registered every cycle.
- Divider: 0..DVSR-1 counter.
  - tick = 1 for one cycle when the counter equals DVSR-1; the counter then wraps to 0.
  - The counter is forced to 0 in the cycle IDLE sees rx_fall, which aligns ticks to the start edge.
- s_cnt: 4-bit tick counter. n: bit counter, $clog2(DATA_BITS) bits. Both change only on tick, except the clears on state entry.
- IDLE: on rx_fall go to START, s_cnt = 0. A line held low does not retrigger; a rising edge is required first.
- START: on tick with s_cnt == 7 (mid start bit):
  - rx_s == 0: go to DATA, s_cnt = 0, n = 0.
  - rx_s == 1: glitch; return to IDLE with no outputs.
  - Otherwise on tick: s_cnt++.
- DATA: on tick with s_cnt == 15: shift = {rx_s, shift[DATA_BITS-1:1]} (LSB first), s_cnt = 0.
  - If n == DATA_BITS-1, go to STOP; else n++.
  - Otherwise on tick: s_cnt++.
- STOP: on tick with s_cnt == SB_TICK-1 (mid stop bit), go to IDLE.
  - rx_s == 1: rx_data <= shift and rx_done_tick = 1 on the same edge; overrun_err = fifo_full in that cycle.
  - rx_s == 0: frame_err = 1; rx_data unchanged; no rx_done_tick.
- Latency: rx_done_tick rises 2 sync cycles + (8 + 16·DATA_BITS + SB_TICK) ticks after the start falling edge at the pin.
- Strobes are registered outputs, high for exactly 1 ckht cycle, and never asserted in the same cycle as each other except overrun_err, which coincides with rx_done_tick.
- Back-to-back frames: a start edge arriving during the second half of the stop bit is caught by IDLE with no lost frame.
- rst mid-frame: immediate abort to IDLE; the partial byte is never emitted.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t.
  - OVERSAMPLE = 16, MID_SAMPLE = 7.
  - Shared with the future uart_tx.
- Sub-module uart_baud_tick: DVSR divider with a synchronous restart input and tick output; reused by the transmitter.

Test Plan:
- Sim uses DVSR = 4 (1 bit = 64 cycles). Send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) -> exactly one rx_done_tick, rx_data = 0xA5, frame_err = 0, strobe 2 + 4·(8 + 128 + 16) cycles after the falling edge ±1.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses, rx_data 0x00 then 0xFF.
- Stop bit driven 0 on byte 0x3C -> frame_err pulses once, no rx_done_tick, rx_data keeps its prior value. Then hold rx high and send 0x55 -> 0x55 received.
- Low glitch of 3 ticks (12 cycles) on an idle line -> return to IDLE, no strobes; a following 0x81 frame is received correctly.
- fifo_full = 1 while 0x7E completes -> rx_done_tick and overrun_err in the same cycle, rx_data = 0x7E.
- Assert rst during the data bits of 0xC3 -> all outputs at reset values that cycle, no strobe from the aborted frame; the next 0x12 frame is received.
